// File: rtl/gf180mcu_clkgen_pkg.sv
// Shared types and helpers for the glitch-free integer clock divider.
// clamp_div yields the effective ratio and its high-phase length.
package gf180mcu_clkgen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MIN_DIV_DEF = 2;

  typedef struct packed {
    logic [31:0] neff;
    logic [31:0] hi;
  } div_t;

  // Odd ratios put the extra cycle in the low phase (HI rounds down).
  function automatic div_t clamp_div(input logic [31:0] div, input logic [31:0] min_div);
    div_t r;
    r.neff = (div < min_div) ? min_div : div;
    r.hi   = r.neff >> 1;
    return r;
  endfunction

endpackage

// File: rtl/gf180mcu_clkgen_cnt.sv
// Loadable period counter; tc_o flags the last cycle of the active period.
module gf180mcu_clkgen_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] n_act_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_inc_o,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_inc_o = cnt_q + ONE;
  assign tc_o      = (cnt_q == (n_act_i - ONE));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkgen_div.sv
// Programmable glitch-free clock divider; Z/STB/BUSY are flop outputs and
// ratio changes or stop requests only take effect at period boundaries.
module gf180mcu_fd_sc_mcu7t5v0__clkgen_div
  import gf180mcu_clkgen_pkg::*;
#(
  parameter int W       = 8,
  parameter int MIN_DIV = MIN_DIV_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] DIV,
  output logic         Z,
  output logic         STB,
  output logic         BUSY,
  inout  wire          VDD,
  inout  wire          VSS
);

  state_e       state_q;
  logic [W-1:0] n_q;
  logic [W-1:0] hi_q;
  logic         z_q;
  logic         stb_q;
  logic         busy_q;

  div_t         clamp;
  logic [W-1:0] neff_w;
  logic [W-1:0] hi_w;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_inc;
  logic         tc;
  logic         cnt_clr;
  logic         cnt_step;

  wire unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  assign clamp  = clamp_div(32'(DIV), 32'(MIN_DIV));
  assign neff_w = W'(clamp.neff);
  assign hi_w   = W'(clamp.hi);

  // Counter advances only inside a running period; it parks at 0 otherwise.
  assign cnt_step = (state_q == RUN) && !tc;
  assign cnt_clr  = !cnt_step;

  gf180mcu_clkgen_cnt #(.W(W)) u_cnt (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_step),
    .n_act_i   (n_q),
    .cnt_o     (cnt),
    .cnt_inc_o (cnt_inc),
    .tc_o      (tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      n_q     <= W'(MIN_DIV);
      hi_q    <= W'(MIN_DIV / 2);
      z_q     <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          z_q    <= 1'b0;
          stb_q  <= 1'b0;
          busy_q <= 1'b0;
          if (EN) begin
            state_q <= RUN;
            n_q     <= neff_w;
            hi_q    <= hi_w;
            z_q     <= 1'b1;
            stb_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (tc) begin
            // Boundary: either start a fresh period with the current DIV or stop.
            if (EN) begin
              n_q    <= neff_w;
              hi_q   <= hi_w;
              z_q    <= 1'b1;
              stb_q  <= 1'b1;
              busy_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              z_q     <= 1'b0;
              stb_q   <= 1'b0;
              busy_q  <= 1'b0;
            end
          end else begin
            z_q    <= (cnt_inc < hi_q);
            stb_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          z_q     <= 1'b0;
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Z    = z_q;
  assign STB  = stb_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkgen_div.sv
// Self-checking bench for the clock divider: vector table, directed
// multi-cycle sequences and a random run against a waveform-queue model.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkgen_div;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [7:0] DIV;
  logic       Z;
  logic       STB;
  logic       BUSY;
  wire        vdd_w = 1'b1;
  wire        vss_w = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__clkgen_div #(.W(8), .MIN_DIV(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .DIV  (DIV),
    .Z    (Z),
    .STB  (STB),
    .BUSY (BUSY),
    .VDD  (vdd_w),
    .VSS  (vss_w)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;
  int stb_cnt = 0;
  logic [15:0] exp_q[$];

  // reference model: each period is pre-expanded into its list of Z levels
  int   wave_q[$];
  bit   m_run;
  logic m_z, m_stb, m_busy;

  task automatic model_start(input logic [7:0] d);
    int neff;
    neff = (d < 2) ? 2 : int'(d);
    wave_q.delete();
    for (int i = 0; i < neff; i++) wave_q.push_back((i < neff / 2) ? 1 : 0);
    m_z    = wave_q.pop_front() != 0;
    m_stb  = 1'b1;
    m_busy = 1'b1;
    m_run  = 1'b1;
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [7:0] d);
    if (r) begin
      m_run = 0; wave_q.delete(); m_z = 0; m_stb = 0; m_busy = 0;
    end else if (m_run && wave_q.size() > 0) begin
      m_z = wave_q.pop_front() != 0;
      m_stb = 0;
    end else if (e) begin
      model_start(d);
    end else begin
      m_run = 0; m_z = 0; m_stb = 0; m_busy = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one CLK cycle, inputs stable across the rising edge, sampled on the falling edge
  task automatic step(input logic r, input logic e, input logic [7:0] d, input bit chk);
    RST = r; EN = e; DIV = d;
    @(posedge CLK);
    model_edge(r, e, d);
    @(negedge CLK);
    if (Z === 1'b1) hi_cnt++;
    if (STB === 1'b1) stb_cnt++;
    if (chk) check("model_zsb", {29'd0, Z, STB, BUSY}, {29'd0, m_z, m_stb, m_busy});
  endtask

  task automatic run_to_stb(input logic e, input logic [7:0] d, output int n);
    n = 0;
    do begin
      step(1'b0, e, d, 1'b1);
      n++;
    end while (STB !== 1'b1 && n < 600);
    if (STB !== 1'b1) check("stb_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[26];

  initial begin
    int n;
    RST = 1'b1; EN = 1'b0; DIV = 8'd4;
    m_run = 0; m_z = 0; m_stb = 0; m_busy = 0;

    // expected {Z,STB,BUSY} after each edge
    vecs[0]  = '{1'b1, 1'b1, 8'd4, 3'b000};
    vecs[1]  = '{1'b1, 1'b1, 8'd4, 3'b000};
    vecs[2]  = '{1'b0, 1'b1, 8'd4, 3'b111};
    vecs[3]  = '{1'b0, 1'b1, 8'd4, 3'b101};
    vecs[4]  = '{1'b0, 1'b1, 8'd4, 3'b001};
    vecs[5]  = '{1'b0, 1'b1, 8'd4, 3'b001};
    vecs[6]  = '{1'b0, 1'b1, 8'd4, 3'b111};
    vecs[7]  = '{1'b0, 1'b1, 8'd4, 3'b101};
    vecs[8]  = '{1'b0, 1'b1, 8'd4, 3'b001};
    vecs[9]  = '{1'b0, 1'b1, 8'd4, 3'b001};
    vecs[10] = '{1'b0, 1'b1, 8'd4, 3'b111};
    vecs[11] = '{1'b0, 1'b1, 8'd3, 3'b101};
    vecs[12] = '{1'b0, 1'b1, 8'd3, 3'b001};
    vecs[13] = '{1'b0, 1'b1, 8'd3, 3'b001};
    vecs[14] = '{1'b0, 1'b1, 8'd3, 3'b111};
    vecs[15] = '{1'b0, 1'b1, 8'd3, 3'b001};
    vecs[16] = '{1'b0, 1'b1, 8'd3, 3'b001};
    vecs[17] = '{1'b0, 1'b1, 8'd3, 3'b111};
    vecs[18] = '{1'b0, 1'b1, 8'd0, 3'b001};
    vecs[19] = '{1'b0, 1'b1, 8'd0, 3'b001};
    vecs[20] = '{1'b0, 1'b1, 8'd0, 3'b111};
    vecs[21] = '{1'b0, 1'b1, 8'd1, 3'b001};
    vecs[22] = '{1'b0, 1'b1, 8'd1, 3'b111};
    vecs[23] = '{1'b0, 1'b1, 8'd1, 3'b001};
    vecs[24] = '{1'b0, 1'b0, 8'd1, 3'b000};
    vecs[25] = '{1'b0, 1'b0, 8'd1, 3'b000};

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].div, 1'b0);
      check($sformatf("vec%0d", i), {29'd0, Z, STB, BUSY}, {29'd0, vecs[i].exp});
    end

    // ratio change mid-period: 6-cycle period completes, then 2-cycle period
    exp_q.push_back(16'd6);
    exp_q.push_back(16'd2);
    step(1'b1, 1'b0, 8'd6, 1'b1);
    hi_cnt = 0;
    step(1'b0, 1'b1, 8'd6, 1'b1);
    run_to_stb(1'b1, 8'd2, n);
    check("div_chg_gap6", n, exp_q.pop_front());
    check("div_chg_hi", hi_cnt, 4);
    run_to_stb(1'b1, 8'd2, n);
    check("div_chg_gap2", n, exp_q.pop_front());

    // stop request mid-period: finish 4 high / 4 low, no extra STB
    step(1'b1, 1'b0, 8'd8, 1'b1);
    hi_cnt = 0; stb_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd8, 1'b1);
    n = 0;
    do begin
      step(1'b0, 1'b0, 8'd8, 1'b1);
      n++;
    end while (BUSY === 1'b1 && n < 20);
    check("stop_steps", n, 6);
    check("stop_hi", hi_cnt, 4);
    check("stop_stb", stb_cnt, 1);
    step(1'b0, 1'b0, 8'd8, 1'b1);
    step(1'b0, 1'b0, 8'd8, 1'b1);
    check("stop_idle", {29'd0, Z, STB, BUSY}, 32'd0);

    // stop cancelled by EN returning before the boundary
    step(1'b0, 1'b1, 8'd8, 1'b1);
    step(1'b0, 1'b1, 8'd8, 1'b1);
    step(1'b0, 1'b1, 8'd8, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd8, 1'b1);
    run_to_stb(1'b1, 8'd8, n);
    check("cancel_gap", n, 3);

    // reset mid-period while Z is high
    step(1'b1, 1'b1, 8'd5, 1'b1);
    step(1'b0, 1'b1, 8'd5, 1'b1);
    step(1'b0, 1'b1, 8'd5, 1'b1);
    check("rst_mid_pre", {29'd0, Z, STB, BUSY}, 32'b101);
    step(1'b1, 1'b1, 8'd5, 1'b1);
    check("rst_mid", {29'd0, Z, STB, BUSY}, 32'b000);
    step(1'b0, 1'b1, 8'd5, 1'b1);
    check("rst_restart", {29'd0, Z, STB, BUSY}, 32'b111);

    // max ratio
    step(1'b1, 1'b1, 8'd255, 1'b1);
    hi_cnt = 0;
    step(1'b0, 1'b1, 8'd255, 1'b1);
    run_to_stb(1'b1, 8'd255, n);
    check("max_gap", n, 255);
    check("max_hi", hi_cnt, 128);
    run_to_stb(1'b1, 8'd255, n);
    check("max_gap2", n, 255);

    // randomized run against the model
    step(1'b1, 1'b0, 8'd2, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic       r, e;
      logic [7:0] d;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      d = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      step(r, e, d, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
